median_col_win_ctrl: RTL and testbench
======================================

// Module: median_col_win_ctrl
// PURPOSE
//  Window sequencer in front of the median column sorter. Buffers two image lines and emits one
//  3-pixel vertical column (rows r-2, r-1, r) per accepted input pixel, with sol/eol/sof/eof framing.
//  Replicates rows at the top/bottom borders and flushes the last row after end of frame.
//  Output count per frame equals input count; latency is one line plus one cycle.
// PARAMETERS
//  DATA_WIDTH  8    pixel width
//  MAX_WIDTH   640  max pixels per line (line buffer depth)
//  ADDR_WIDTH  10   column counter / buffer address width, 2**ADDR_WIDTH >= MAX_WIDTH
// PORTS
//  clk        in   1           clock; all logic on posedge
//  rst_n      in   1           asynchronous active-low reset
//  pix_data   in   DATA_WIDTH  input pixel
//  pix_val    in   1           input valid
//  pix_rdy    out  1           input ready
//  pix_sol/pix_eol/pix_sof/pix_eof  in  1 each  input framing, qualified by pix_val
//  win_pix0   out  DATA_WIDTH  top pixel (row r-2, or replicated)
//  win_pix1   out  DATA_WIDTH  centre pixel (row r-1)
//  win_pix2   out  DATA_WIDTH  bottom pixel (row r, or replicated)
//  win_val    out  1           output valid
//  win_rdy    in   1           output ready (from sorter)
//  win_sol/win_eol/win_sof/win_eof  out  1 each  output framing, aligned with win_val
//  err        out  1           sticky protocol error, cleared only by reset
// BEHAVIOUR
//  - Reset: state=IDLE, win_* = 0, err = 0, counters and flags = 0. Line buffer RAM is not reset.
//    Reset mid-frame aborts the frame; the next frame starts at IDLE.
//  - Buffers: lb0 holds row r-1 and lb1 holds row r-2. Both are read combinationally at col.
//    Both are written on the accepted pixel.
//  - Output stage: a single register slot. slot_free = ~win_val | win_rdy.
//    win_val clears on win_rdy when no new beat is loaded.
//  - pix_rdy = (state==IDLE) | (state==FILL) | (state==RUN & slot_free). pix_rdy = 0 in FLUSH.
//  - IDLE: pixels without pix_sof are dropped and set err. An accepted sof pixel is handled as FILL col 0.
//  - FILL (row 0): lb0[col] <= pix_data. No output is produced.
//    On eol: width <= col+1, col <= 0, go to RUN. If eof is also set, set single_row and go to FLUSH.
//  - RUN (row r >= 1), on accept at col c:
//    - load the slot with {lb1[c], lb0[c], pix_data}, or {lb0[c], lb0[c], pix_data} when r==1;
//    - lb1[c] <= lb0[c]; lb0[c] <= pix_data.
//    - win_sol = (c==0). win_eol = pix_eol. win_sof = (r==1 & c==0). win_eof = 0.
//    - On eol: col <= 0, r++. If eof is also set, go to FLUSH.
//  - FLUSH: col steps 0..width-1, one beat per cycle while slot_free.
//    - Beat = {lb1[c], lb0[c], lb0[c]}, or {lb0, lb0, lb0} when single_row or r==1.
//    - win_eof is set on the last beat, together with win_eol. win_sof is set on c==0 only if single_row.
//    - After the last beat is loaded, go to IDLE.
//  - Line width comes from the first eol only.
//    - A later eol at a different column sets err; the row ends at that eol.
//    - A sof outside IDLE sets err and the pixel is treated as ordinary.
//  - Overflow: if col reaches MAX_WIDTH-1 without eol, set err.
//    Further pixels of that row are accepted but discarded (no write, no output) until eol.
//  - Simultaneous accept and output drain in the same cycle is allowed, giving full throughput
//    of 1 pixel/cycle in RUN.
// STRUCTURE
//  - Shared package median_pkg: state encoding (IDLE, FILL, RUN, FLUSH), DATA_WIDTH default,
//    MAX_WIDTH default.
//  - One sub-module, median_line_buf: single-port-write / async-read RAM,
//    DATA_WIDTH x MAX_WIDTH, instantiated twice.
//  - FSM, counters and output slot stay in this module.
// TESTING
//  1. 4x3 frame, rows 10..13 / 20..23 / 30..33, win_rdy=1 -> 12 beats. Row0 cols = {10,10,20}..{13,13,23}.
//     Row1 = {10,20,30}.. Row2 = {20,30,30}..{23,33,33}. sof on beat 0, eof on beat 11.
//  2. Single-row frame 5,6,7 (sof + eol + eof) -> 3 beats {5,5,5},{6,6,6},{7,7,7}, sof on the first, eof on the last.
//  3. Test 1 with win_rdy toggling 1-0-1 -> pix_rdy low whenever the slot is held. Same 12 beats, no loss or duplication.
//  4. Reset asserted mid-row 1 -> outputs 0 next edge. New 4x3 frame reproduces test 1 exactly.
//  5. Second row eol at col 2 of width 4 -> err=1, row ends at col 2, frame still flushes.
//  6. Pixel without sof in IDLE -> dropped, err=1, no win_val.

Source files
------------

// File: rtl/median_pkg.sv
// Shared state encoding and default geometry for the median filter window path.
package median_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_WIDTH_DEF  = 640;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;
endpackage

// File: rtl/median_line_buf.sv
// One-line pixel store: synchronous write, combinational read, no reset on contents.
module median_line_buf
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = MAX_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/median_col_win_ctrl.sv
// Emits a 3-row vertical column per accepted pixel, one line + one cycle behind the input.
// pix_rdy drops while the single output slot is held in RUN and for the whole end-of-frame flush.
module median_col_win_ctrl
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_val,
  output logic                  pix_rdy,
  input  logic                  pix_sol,
  input  logic                  pix_eol,
  input  logic                  pix_sof,
  input  logic                  pix_eof,
  output logic [DATA_WIDTH-1:0] win_pix0,
  output logic [DATA_WIDTH-1:0] win_pix1,
  output logic [DATA_WIDTH-1:0] win_pix2,
  output logic                  win_val,
  input  logic                  win_rdy,
  output logic                  win_sol,
  output logic                  win_eol,
  output logic                  win_sof,
  output logic                  win_eof,
  output logic                  err
);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(MAX_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_ONE  = ADDR_WIDTH'(1);

  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] col, col_nxt, width_m1, width_nxt;
  logic row_one, row_one_nxt, single_row, single_nxt, ovf, ovf_nxt, err_set;
  logic [DATA_WIDTH-1:0] rd0, rd1, b0, b1, b2;
  logic bsol, beol, bsof, beof;
  logic wr0, wr1, load, slot_free, acc, proc, keep;
  logic unused_sol;

  assign unused_sol = pix_sol;
  assign slot_free  = ~win_val | win_rdy;
  assign pix_rdy    = (state == IDLE) | (state == FILL) | ((state == RUN) & slot_free);
  assign acc        = pix_val & pix_rdy;

  // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old value
  median_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lb0 (
    .clk(clk), .wr_en(wr0), .wr_addr(col), .wr_data(pix_data), .rd_addr(col), .rd_data(rd0)
  );
  median_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lb1 (
    .clk(clk), .wr_en(wr1), .wr_addr(col), .wr_data(rd0), .rd_addr(col), .rd_data(rd1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    width_nxt   = width_m1;
    row_one_nxt = row_one;
    single_nxt  = single_row;
    ovf_nxt     = ovf;
    err_set     = 1'b0;
    wr0         = 1'b0;
    wr1         = 1'b0;
    load        = 1'b0;
    b0          = rd1;
    b1          = rd0;
    b2          = pix_data;
    bsol        = (col == '0);
    beol        = 1'b0;
    bsof        = 1'b0;
    beof        = 1'b0;
    // an IDLE pixel only counts if it opens a frame
    proc        = acc & ((state != IDLE) | pix_sof);
    keep        = proc & ~ovf;

    if (acc & (state == IDLE) & ~pix_sof) err_set = 1'b1;
    if (acc & (state != IDLE) & pix_sof)  err_set = 1'b1;

    if (proc) begin
      if (pix_eol) begin
        col_nxt = '0;
        ovf_nxt = 1'b0;
        if (state == RUN) begin
          if (col != width_m1) err_set = 1'b1;
          row_one_nxt = 1'b0;
          if (pix_eof) state_nxt = FLUSH;
        end else begin
          width_nxt   = col;
          row_one_nxt = 1'b1;
          single_nxt  = pix_eof;
          state_nxt   = pix_eof ? FLUSH : RUN;
        end
      end else begin
        if (state == IDLE) state_nxt = FILL;
        if (!ovf) begin
          if (col == COL_LAST) begin
            ovf_nxt = 1'b1;
            err_set = 1'b1;
          end else begin
            col_nxt = col + COL_ONE;
          end
        end
      end
    end

    if (keep) begin
      wr0 = 1'b1;
      if (state == RUN) begin
        wr1  = 1'b1;
        load = 1'b1;
        if (row_one) b0 = rd0;
        beol = pix_eol;
        bsof = row_one & (col == '0);
      end
    end

    // last row has no row below it: replicate it as the bottom pixel
    if ((state == FLUSH) & slot_free) begin
      load = 1'b1;
      b2   = rd0;
      if (single_row | row_one) b0 = rd0;
      beol = (col == width_m1);
      beof = beol;
      bsof = single_row & (col == '0);
      if (col == width_m1) begin
        col_nxt     = '0;
        state_nxt   = IDLE;
        single_nxt  = 1'b0;
        row_one_nxt = 1'b0;
      end else begin
        col_nxt = col + COL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      width_m1   <= '0;
      row_one    <= 1'b0;
      single_row <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      win_val    <= 1'b0;
      win_pix0   <= '0;
      win_pix1   <= '0;
      win_pix2   <= '0;
      win_sol    <= 1'b0;
      win_eol    <= 1'b0;
      win_sof    <= 1'b0;
      win_eof    <= 1'b0;
    end else begin
      col        <= col_nxt;
      width_m1   <= width_nxt;
      row_one    <= row_one_nxt;
      single_row <= single_nxt;
      ovf        <= ovf_nxt;
      if (err_set) err <= 1'b1;
      if (load) begin
        win_val  <= 1'b1;
        win_pix0 <= b0;
        win_pix1 <= b1;
        win_pix2 <= b2;
        win_sol  <= bsol;
        win_eol  <= beol;
        win_sof  <= bsof;
        win_eof  <= beof;
      end else if (win_rdy) begin
        win_val <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_median_col_win_ctrl.sv
// Scoreboarded bench: each output beat is the clamped row triple {k-1, k, k+1} of the input frame.
module tb_median_col_win_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_data;
  logic       pix_val, pix_rdy, pix_sol, pix_eol, pix_sof, pix_eof;
  logic [7:0] win_pix0, win_pix1, win_pix2;
  logic       win_val, win_rdy, win_sol, win_eol, win_sof, win_eof, err;

  always #5 clk = ~clk;

  median_col_win_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pix_data(pix_data), .pix_val(pix_val), .pix_rdy(pix_rdy),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .win_pix0(win_pix0), .win_pix1(win_pix1), .win_pix2(win_pix2),
    .win_val(win_val), .win_rdy(win_rdy),
    .win_sol(win_sol), .win_eol(win_eol), .win_sof(win_sof), .win_eof(win_eof),
    .err(err)
  );

  typedef logic [27:0] beat_t;
  beat_t exp_q[$];
  int    fr[$];
  int    errors = 0;
  int    checks = 0;
  int    rdy_mode = 0;
  bit    chk_hold = 1'b0;

  function automatic beat_t mk(int a, int b, int c, bit sol, bit eol, bit sof, bit eof);
    return {8'(a), 8'(b), 8'(c), sol, eol, sof, eof};
  endfunction

  function automatic int px(int w, int r, int c);
    return fr[r * w + c];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t act, e;
    if (rst_n === 1'b1) begin
      if (win_val && win_rdy) begin
        act = {win_pix0, win_pix1, win_pix2, win_sol, win_eol, win_sof, win_eof};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got=%h exp=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat got=%h exp=%h", act, e);
          end
        end
      end
      if (chk_hold && win_val && !win_rdy) begin
        checks++;
        if (pix_rdy !== 1'b0) begin
          errors++;
          $display("FAIL hold_pix_rdy got=%b exp=0", pix_rdy);
        end
      end
    end
  end

  initial begin
    win_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       win_rdy = 1'b1;
        1:       win_rdy = ~win_rdy;
        default: win_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input int d, input bit sol, input bit eol, input bit sof, input bit eof,
                      input int gap);
    bit got;
    got = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    pix_data = 8'(d);
    pix_sol = sol; pix_eol = eol; pix_sof = sof; pix_eof = eof;
    pix_val = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pix_rdy) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=no_pix_rdy exp=pix_rdy");
    end
    @(posedge clk); #1;
    pix_val = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int maxgap, input int npix);
    int total, r, c;
    total = (npix < 0) ? w * h : npix;
    for (int k = 0; k < h; k++)
      for (int j = 0; j < w; j++)
        exp_q.push_back(mk(px(w, (k == 0) ? 0 : k - 1, j), px(w, k, j),
                           px(w, (k == h - 1) ? k : k + 1, j),
                           j == 0, j == w - 1, k == 0 && j == 0, k == h - 1 && j == w - 1));
    for (int i = 0; i < total; i++) begin
      r = i / w;
      c = i % w;
      if (r == 1 && c == 0) chk_hold = 1'b1;
      send(px(w, r, c), c == 0, c == w - 1, i == 0, i == w * h - 1,
           int'($urandom_range(0, maxgap)));
    end
    chk_hold = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_win_val", win_val, 0);
    check("rst_win_pix", {win_pix0, win_pix1, win_pix2}, 0);
    check("rst_err", err, 0);
    check("rst_pix_rdy", pix_rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_grid(input int w, input int h);
    fr.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) fr.push_back(10 * (r + 1) + c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int t5_pix[11] = '{40, 41, 42, 43, 50, 51, 52, 60, 61, 62, 63};
  bit t5_eol[11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    int w, h;
    rst_n = 1'b0;
    pix_val = 1'b0; pix_data = '0;
    pix_sol = 1'b0; pix_eol = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
    #3;
    do_reset();

    // 4x3 reference frame, sorter always ready
    load_grid(4, 3);
    run_frame(4, 3, 0, -1);
    drain();
    check("t1_err", err, 0);

    // single-row frame
    fr = '{5, 6, 7};
    run_frame(3, 1, 0, -1);
    drain();
    check("t2_err", err, 0);

    // sorter stalls every other cycle
    rdy_mode = 1;
    load_grid(4, 3);
    run_frame(4, 3, 0, -1);
    drain();
    rdy_mode = 0;
    check("t3_err", err, 0);

    // abort in the middle of row 1, then replay the full frame
    load_grid(4, 3);
    run_frame(4, 3, 0, 6);
    do_reset();
    run_frame(4, 3, 0, -1);
    drain();
    check("t4_err", err, 0);

    // short second row; lb1 col 3 still holds the previous frame's row 1 (23)
    exp_q.push_back(mk(40, 40, 50, 1, 0, 1, 0));
    exp_q.push_back(mk(41, 41, 51, 0, 0, 0, 0));
    exp_q.push_back(mk(42, 42, 52, 0, 1, 0, 0));
    exp_q.push_back(mk(40, 50, 60, 1, 0, 0, 0));
    exp_q.push_back(mk(41, 51, 61, 0, 0, 0, 0));
    exp_q.push_back(mk(42, 52, 62, 0, 0, 0, 0));
    exp_q.push_back(mk(23, 43, 63, 0, 1, 0, 0));
    exp_q.push_back(mk(50, 60, 60, 1, 0, 0, 0));
    exp_q.push_back(mk(51, 61, 61, 0, 0, 0, 0));
    exp_q.push_back(mk(52, 62, 62, 0, 0, 0, 0));
    exp_q.push_back(mk(43, 63, 63, 0, 1, 0, 1));
    for (int i = 0; i < 11; i++)
      send(t5_pix[i], i == 0 || i == 4 || i == 7, t5_eol[i], i == 0, i == 10, 0);
    drain();
    check("t5_err", err, 1);

    // stray pixel while idle
    do_reset();
    send(99, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_err", err, 1);
    check("t6_win_val", win_val, 0);
    drain();

    // random frames with random sorter backpressure and input gaps
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      w = int'($urandom_range(1, 8));
      h = int'($urandom_range(1, 5));
      fr.delete();
      for (int i = 0; i < w * h; i++) fr.push_back(int'($urandom_range(0, 255)));
      run_frame(w, h, 2, -1);
      drain();
    end
    rdy_mode = 0;
    check("rand_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
